// File: rtl/comp_pkg.sv
// comp_pkg: shared definitions for the comparator flag output stage.
//   - Flag word layout XXXXXGEL: bit indices of L/E/G and the word width.
//   - Skid-buffer occupancy encoding.
//   - flag_illegal(): legality check for a comparator flag word.
package comp_pkg;

    localparam int unsigned FLAG_W = 8;
    localparam int unsigned FLAG_L = 0;
    localparam int unsigned FLAG_E = 1;
    localparam int unsigned FLAG_G = 2;

    // Buffer occupancy: nothing, main register only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // A legal word has exactly one of G/E/L set and all upper bits clear.
    function automatic logic flag_illegal(input logic [FLAG_W-1:0] f);
        logic [1:0] n_set;
        n_set = 2'(f[FLAG_L]) + 2'(f[FLAG_E]) + 2'(f[FLAG_G]);
        return (n_set != 2'd1) || (f[FLAG_W-1:3] != '0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that saturates at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear, takes priority over inc
//   count      : current count
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/comp_flag_stage.sv
// comp_flag_stage: registered output stage behind the 8-bit comparator.
//   Upstream  : in_valid/in_ready handshake carrying {in_A, in_B, in_F}.
//   Downstream: out_valid/out_ready handshake carrying {out_A, out_B, out_F}
//               plus out_bad, set when the buffered flag word is illegal.
//   Status    : saturating cnt_gt/cnt_eq/cnt_lt counters and err_sticky,
//               all cleared synchronously by clr.
// A 2-entry skid buffer (main + skid) keeps in_ready a pure function of
// state, so the consumer's stall never reaches the comparator path.
module comp_flag_stage
    import comp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_A,
    input  logic [DATA_W-1:0] in_B,
    input  logic [FLAG_W-1:0] in_F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B,
    output logic [FLAG_W-1:0] out_F,
    output logic              out_bad,
    input  logic              clr,
    output logic [CNT_W-1:0]  cnt_gt,
    output logic [CNT_W-1:0]  cnt_eq,
    output logic [CNT_W-1:0]  cnt_lt,
    output logic              err_sticky
);

    buf_state_e state_q, state_d;

    logic [DATA_W-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
    logic [FLAG_W-1:0] main_f_q, skid_f_q;
    logic              main_bad_q, skid_bad_q;
    logic              err_q;

    logic up_fire, dn_fire, in_bad;
    logic load_main, load_skid, shift_skid;

    assign up_fire = in_valid & in_ready;
    assign dn_fire = out_valid & out_ready;
    assign in_bad  = flag_illegal(in_F);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath load enables
    always_comb begin
        state_d    = state_q;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (up_fire) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (up_fire && dn_fire) begin
                    load_main = 1'b1;
                end else if (up_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (dn_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a downstream fire can happen.
                if (dn_fire) begin
                    state_d    = ONE;
                    shift_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        unique case (state_q)
            EMPTY: ;
            ONE:   out_valid = 1'b1;
            FULL: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_a_q   <= '0;
            main_b_q   <= '0;
            main_f_q   <= '0;
            main_bad_q <= 1'b0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_f_q   <= '0;
            skid_bad_q <= 1'b0;
        end else begin
            if (load_main) begin
                main_a_q   <= in_A;
                main_b_q   <= in_B;
                main_f_q   <= in_F;
                main_bad_q <= in_bad;
            end else if (shift_skid) begin
                main_a_q   <= skid_a_q;
                main_b_q   <= skid_b_q;
                main_f_q   <= skid_f_q;
                main_bad_q <= skid_bad_q;
            end
            if (load_skid) begin
                skid_a_q   <= in_A;
                skid_b_q   <= in_B;
                skid_f_q   <= in_F;
                skid_bad_q <= in_bad;
            end
        end
    end

    assign out_A   = main_a_q;
    assign out_B   = main_b_q;
    assign out_F   = main_f_q;
    assign out_bad = main_bad_q;

    // clr beats a same-cycle accept: that entry is neither counted nor flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else if (up_fire && in_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_sticky = err_q;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_gt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (up_fire & in_F[FLAG_G]),
        .clr   (clr),
        .count (cnt_gt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_eq (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (up_fire & in_F[FLAG_E]),
        .clr   (clr),
        .count (cnt_eq)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_lt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (up_fire & in_F[FLAG_L]),
        .clr   (clr),
        .count (cnt_lt)
    );

endmodule

// File: tb/tb_comp_flag_stage.sv
// tb_comp_flag_stage: drives two instances (CNT_W=8 and CNT_W=4) with the same
// stimulus and compares both against a queue-based reference model with
// uncapped event totals that are saturated only when compared.
module tb_comp_flag_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid, out_ready, clr;
    logic [7:0] in_A, in_B, in_F;

    logic       r8, v8, bad8, err8;
    logic [7:0] a8, b8, f8, gt8, eq8, lt8;
    logic       r4, v4, bad4, err4;
    logic [7:0] a4, b4, f4;
    logic [3:0] gt4, eq4, lt4;

    comp_flag_stage #(.DATA_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8),
        .in_A(in_A), .in_B(in_B), .in_F(in_F), .out_valid(v8), .out_ready(out_ready),
        .out_A(a8), .out_B(b8), .out_F(f8), .out_bad(bad8), .clr(clr),
        .cnt_gt(gt8), .cnt_eq(eq8), .cnt_lt(lt8), .err_sticky(err8)
    );

    comp_flag_stage #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4),
        .in_A(in_A), .in_B(in_B), .in_F(in_F), .out_valid(v4), .out_ready(out_ready),
        .out_A(a4), .out_B(b4), .out_F(f4), .out_bad(bad4), .clr(clr),
        .cnt_gt(gt4), .cnt_eq(eq4), .cnt_lt(lt4), .err_sticky(err4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] f;
    } ent_t;

    ent_t q[$];
    int   mg, me, ml;
    bit   merr;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic ill(input logic [7:0] f);
        return ($countones(f[2:0]) != 1) || (f[7:3] != '0);
    endfunction

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic check_outputs();
        chk("out_valid8", v8, q.size() != 0);
        chk("out_valid4", v4, q.size() != 0);
        chk("in_ready8", r8, q.size() < 2);
        chk("in_ready4", r4, q.size() < 2);
        if (q.size() != 0) begin
            chk("out_A8", a8, q[0].a);
            chk("out_B8", b8, q[0].b);
            chk("out_F8", f8, q[0].f);
            chk("out_bad8", bad8, ill(q[0].f));
            chk("out_A4", a4, q[0].a);
            chk("out_B4", b4, q[0].b);
            chk("out_F4", f4, q[0].f);
            chk("out_bad4", bad4, ill(q[0].f));
        end
        chk("cnt_gt8", gt8, sat(mg, 8));
        chk("cnt_eq8", eq8, sat(me, 8));
        chk("cnt_lt8", lt8, sat(ml, 8));
        chk("cnt_gt4", gt4, sat(mg, 4));
        chk("cnt_eq4", eq4, sat(me, 4));
        chk("cnt_lt4", lt4, sat(ml, 4));
        chk("err_sticky8", err8, merr);
        chk("err_sticky4", err4, merr);
    endtask

    // One clock cycle: drive, check, clock, then advance the model.
    task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] f, input bit ordy, input bit c);
        bit up, dn;
        in_valid  = v;
        in_A      = a;
        in_B      = b;
        in_F      = f;
        out_ready = ordy;
        clr       = c;
        #1;
        check_outputs();
        up = v && (q.size() < 2);
        dn = (q.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (dn) void'(q.pop_front());
        if (up) q.push_back('{a: a, b: b, f: f});
        if (c) begin
            mg = 0; me = 0; ml = 0; merr = 1'b0;
        end else if (up) begin
            mg += int'(f[2]);
            me += int'(f[1]);
            ml += int'(f[0]);
            if (ill(f)) merr = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        bit         pv;
        bit         acc;
        ent_t       pe;
        logic [7:0] ill_words [3];

        mg = 0; me = 0; ml = 0; merr = 1'b0;
        in_valid = 1'b0; in_A = '0; in_B = '0; in_F = '0; out_ready = 1'b0; clr = 1'b0;

        // Reset values while rst_n is held low
        #12;
        chk("rst_out_valid", v8, 1'b0);
        chk("rst_in_ready", r8, 1'b1);
        chk("rst_out_A", a8, 8'h00);
        chk("rst_out_B", b8, 8'h00);
        chk("rst_out_F", f8, 8'h00);
        chk("rst_out_bad", bad8, 1'b0);
        chk("rst_cnt_gt", gt8, 8'h00);
        chk("rst_err", err8, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single transfer
        cycle(1'b1, 8'h05, 8'h03, 8'h04, 1'b1, 1'b0);
        idle(2);

        // Back-pressure: third offer is refused and held until space frees up
        cycle(1'b1, 8'h10, 8'h20, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 8'h21, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 8'h22, 8'h04, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 8'h22, 8'h04, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 8'h22, 8'h04, 1'b1, 1'b0);
        cycle(1'b1, 8'h12, 8'h22, 8'h04, 1'b1, 1'b0);
        idle(3);

        // Zero-bubble stream of legal words
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 8'(8'h01 << $urandom_range(0, 2)),
                  1'b1, 1'b0);
        end
        idle(2);

        // Illegal words, then clr
        ill_words = '{8'h06, 8'h00, 8'h0C};
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h33, 8'h44, ill_words[i], 1'b1, 1'b0);
        idle(2);
        cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        idle(1);

        // Saturation of the 4-bit counter, then clr racing an accept
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), 8'(i), 8'h02, 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 8'h66, 8'h01, 1'b1, 1'b1);
        idle(2);

        // Randomized traffic; upstream holds an offer until accepted
        pv = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!pv) begin
                pv   = ($urandom_range(0, 3) != 0);
                pe.a = 8'($urandom);
                pe.b = 8'($urandom);
                pe.f = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                   : 8'(8'h01 << $urandom_range(0, 2));
            end
            acc = pv && (q.size() < 2);
            cycle(pv, pe.a, pe.b, pe.f, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            if (acc) pv = 1'b0;
        end
        idle(3);

        // Fill to FULL, then asynchronous reset between edges
        cycle(1'b1, 8'hA1, 8'hB1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 8'hB2, 8'h04, 1'b0, 1'b0);
        chk("full_in_ready", r8, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid8", v8, 1'b0);
        chk("arst_in_ready8", r8, 1'b1);
        chk("arst_out_valid4", v4, 1'b0);
        chk("arst_in_ready4", r4, 1'b1);
        chk("arst_cnt_gt8", gt8, 8'h00);
        chk("arst_cnt_lt8", lt8, 8'h00);
        chk("arst_cnt_eq4", eq4, 4'h0);
        chk("arst_err", err8, 1'b0);
        q.delete();
        mg = 0; me = 0; ml = 0; merr = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h5A, 8'hA5, 8'h02, 1'b1, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/comp_flag_stage.md
Name: comp_flag_stage

Overview:
- Registered output stage directly downstream of the 8-bit comparator.
- Accepts {A, B, F} with a valid/ready handshake and buffers it in a 2-entry skid buffer so the comparator path is not combinationally coupled to the consumer's stall.
- Maintains saturating G/E/L event counters and a sticky illegal-flag error for the ALU status logic.
- Flag word format is XXXXXGEL: bit 0 = L (A<B), bit 1 = E (A==B), bit 2 = G (A>B), bits 3..7 = 0.

Parameters:
- DATA_W, 8, operand width of A and B.
- CNT_W, 8, width of each event counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds {in_A, in_B, in_F} valid.
- in_ready  out  1  stage can accept; registered.
- in_A  in  DATA_W  operand A presented to comparator.
- in_B  in  DATA_W  operand B presented to comparator.
- in_F  in  8  comparator flag word, XXXXXGEL.
- out_valid  out  1  {out_A, out_B, out_F} valid; registered.
- out_ready  in  1  consumer accepts.
- out_A  out  DATA_W  buffered A.
- out_B  out  DATA_W  buffered B.
- out_F  out  8  buffered flag word, unmodified.
- out_bad  out  1  buffered entry's flag word was illegal.
- clr  in  1  synchronous clear of counters and sticky error.
- cnt_gt  out  CNT_W  accepted entries with G set.
- cnt_eq  out  CNT_W  accepted entries with E set.
- cnt_lt  out  CNT_W  accepted entries with L set.
- err_sticky  out  1  an illegal flag word has been accepted since reset/clr.

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; out_valid=0; in_ready=1; out_A/out_B/out_F=0; out_bad=0; counters=0; err_sticky=0. in_ready stays 1 while rst_n is low. Reset mid-transfer drops all buffered entries.
- Transfers: upstream fires when in_valid & in_ready; downstream fires when out_valid & out_ready, sampled at the rising edge.
- States:
  - EMPTY: out_valid=0, in_ready=1. Upstream fire -> ONE.
  - ONE: main register holds the entry; out_valid=1, in_ready=1.
    - Upstream fire only -> FULL (new entry goes to skid).
    - Downstream fire only -> EMPTY.
    - Both fire -> ONE (new entry loads main).
  - FULL: main and skid both hold entries; out_valid=1, in_ready=0.
    - Downstream fire -> ONE (skid moves to main).
- Latency: an entry accepted at edge N is on the out_* ports after edge N; out_valid=1 in cycle N+1. FIFO order is preserved. Zero-bubble throughput of 1 entry/cycle when out_ready is held high.
- out_* hold stable while out_valid=1 and out_ready=0. in_valid while in_ready=0 is ignored; upstream must hold its data.
- Illegal flag word: the number of set bits among F[0..2] is not exactly 1, or any of F[3..7] is 1. Such an entry is still buffered and forwarded, with out_bad=1 alongside it.
- Counters update on each upstream fire:
  - cnt_gt += F[2], cnt_eq += F[1], cnt_lt += F[0], each independently and counted even for illegal words.
  - Each counter saturates at all-ones and never wraps.
  - err_sticky is set when an illegal word is accepted.
- clr: sets counters and err_sticky to 0 at the next edge. If clr and an upstream fire occur in the same cycle, clr wins: that entry is not counted and does not set err_sticky, but is still buffered and forwarded. clr does not affect the buffer or the handshake.

Decomposition:
- Shared package comp_pkg:
  - flag bit indices FLAG_L=0, FLAG_E=1, FLAG_G=2; flag word width 8.
  - buffer state encoding EMPTY/ONE/FULL.
  - function flag_illegal(F).
- One sub-module, sat_counter (CNT_W, inc, clr, count), instantiated three times.
- The buffer control stays in comp_flag_stage.

Test Plan:
- Reset then a single transfer of A=8'h05, B=8'h03, F=8'h04 with out_ready=1 -> out_valid=1 the next cycle with out_F=8'h04 and out_bad=0; cnt_gt=1, cnt_eq=0, cnt_lt=0.
- Hold out_ready=0 and offer 3 entries (F=01, 02, 04) -> 2 accepted, in_ready=0 after the second; out_F stays 8'h01. Release out_ready -> outputs 01, 02, 04 in order with no loss or duplication.
- Back-to-back stream of 100 entries with out_ready=1 -> one output per cycle after 1-cycle latency; in_ready never drops.
- Illegal words F=8'h06, 8'h00 and 8'h0C -> each forwarded with out_bad=1; err_sticky=1. For 8'h06: cnt_gt and cnt_eq each +1. A following clr -> all counters 0 and err_sticky=0.
- CNT_W=4: 20 accepted entries with F=8'h02 -> cnt_eq saturates at 4'hF. clr in the same cycle as an accepted F=8'h01 -> cnt_lt=0 afterwards, and the entry still appears on out_F.
- Assert rst_n low while in state FULL -> immediately out_valid=0, in_ready=1 and counters 0. After release, the first new entry is output correctly.
